// File: rtl/vna_switch_sequencer_if.sv
// Host-side command and status bus of the VNA switch sequencer.
// cmd_valid is a one-cycle strobe with no ready: the sequencer consumes every strobe, acting on it or answering with cmd_err.
interface vna_switch_sequencer_if #(
  parameter int CH_W = 2
) ();
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic [CH_W-1:0] cmd_ch;
  logic [CH_W-1:0] cur_ch;
  logic            busy;
  logic            sweep_done;
  logic            timeout_err;
  logic            cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch,
    input  cur_ch, busy, sweep_done, timeout_err, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch,
    output cur_ch, busy, sweep_done, timeout_err, cmd_err
  );
endinterface

// File: rtl/vna_switch_sequencer.sv
// Active-low one-hot RF switch sequencer: settle, delayed VNA trigger pulse, then wait for
// the VNA ready edge, per channel. Manual select, single sweep and continuous sweep.
module vna_switch_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int TRIG_DLY    = 5,
  parameter int TRIG_LEN    = 25,
  parameter int RDY_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                VNA_RDY,
  vna_switch_sequencer_if.slave host,
  output logic                VNA_TRIG,
  output logic [NUM_CH-1:0]   sw_n,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_TRIG     = 2'd2,
    ST_WAIT_RDY = 2'd3
  } state_e;

  localparam logic [1:0] OP_SELECT     = 2'd0;
  localparam logic [1:0] OP_SWEEP_ONCE = 2'd1;
  localparam logic [1:0] OP_SWEEP_LOOP = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TRIG_ON     = CNT_W'(TRIG_DLY);
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_DLY + TRIG_LEN - 1);
  localparam logic [CNT_W-1:0] RDY_LAST    = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                loop_q, loop_d;
  logic                trig_q, trig_d;
  logic                busy_q;
  logic                done_q, done_d;
  logic                to_q, to_d;
  logic                err_q, err_d;
  logic [NUM_CH-1:0]   sw_n_q, sw_n_d;
  logic                sync1_q, sync2_q, hist_q;
  logic                rdy_edge;

  assign rdy_edge = sync2_q & ~hist_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_inc;
    loop_d  = loop_q;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (host.cmd_valid) begin
          case (host.cmd_op)
            OP_SELECT: begin
              if (host.cmd_ch <= CH_LAST) sel_d = host.cmd_ch;
              else                        err_d = 1'b1;
            end
            OP_SWEEP_ONCE, OP_SWEEP_LOOP: begin
              sel_d   = '0;
              loop_d  = (host.cmd_op == OP_SWEEP_LOOP);
              state_d = ST_SETTLE;
            end
            default: ;
          endcase
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_TRIG;
          cnt_d   = '0;
          trig_d  = (TRIG_ON == '0);
        end
      end
      ST_TRIG: begin
        if (cnt_q >= TRIG_LAST) begin
          state_d = ST_WAIT_RDY;
          cnt_d   = '0;
        end else begin
          trig_d = (cnt_inc >= TRIG_ON);
        end
      end
      ST_WAIT_RDY: begin
        // Any command in this cycle takes priority; the edge or timeout is simply lost.
        if (!host.cmd_valid) begin
          if (rdy_edge) begin
            cnt_d = '0;
            if (sel_q != CH_LAST) begin
              sel_d   = sel_q + CH_W'(1);
              state_d = ST_SETTLE;
            end else if (loop_q) begin
              sel_d   = '0;
              state_d = ST_SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (cnt_q >= RDY_LAST) begin
            to_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // While busy only STOP is honoured; other commands are refused but phase timing runs on.
    if (state_q != ST_IDLE && host.cmd_valid) begin
      if (host.cmd_op == OP_STOP) begin
        state_d = ST_IDLE;
        sel_d   = sel_q;
        cnt_d   = '0;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        to_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      sw_n_d[i] = (sel_d != CH_W'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      sw_n_q  <= {{(NUM_CH-1){1'b1}}, 1'b0};
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      trig_q  <= trig_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      to_q    <= to_d;
      err_q   <= err_d;
      sw_n_q  <= sw_n_d;
      sync1_q <= VNA_RDY;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign VNA_TRIG         = trig_q;
  assign sw_n             = sw_n_q;
  assign dbg_state_o      = state_q;
  assign host.cur_ch      = sel_q;
  assign host.busy        = busy_q;
  assign host.sweep_done  = done_q;
  assign host.timeout_err = to_q;
  assign host.cmd_err     = err_q;

endmodule
